mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Responder side of the core memory-request interface: accepts mem_rq_* requests from ucore,
//  runs them as one or two byte cycles on an 8-bit external bus, and returns read data on
//  mem_data_in / mem_data_wr / mem_data_t_wr for the reservation stations.
//  Drives hold back to the core while a transaction is in flight. One outstanding request at a time.
// PARAMETERS
//  TIMEOUT  16  bus-phase cycles without bus_ack before abort; 0 disables the timeout
// PORTS
//  clk            in   1   clock, all state on rising edge
//  a_rst          in   1   asynchronous reset, active-low (0 = reset)
//  mem_rq_start   in   1   request strobe from core, one cycle
//  mem_rq_cmd     in   1   0 = read, 1 = write
//  mem_rq_width   in   1   0 = byte, 1 = word (16b little-endian)
//  mem_rq_prepare_addr in 1 latch mem_rq_addr into MAR
//  mem_rq_addr    in   16  address, valid with prepare_addr
//  mem_rq_data    in   16  write data, valid with mem_rq_start
//  mem_rq_tag     in   1   destination station for read data (0 = rsa, 1 = rsb)
//  hold           out  1   busy: high while state != IDLE
//  mem_data_in    out  16  read result
//  mem_data_wr    out  1   one-cycle read-return strobe
//  mem_data_t_wr  out  1   tag of the returning read, valid with mem_data_wr
//  wr_done        out  1   one-cycle write-completion strobe
//  bus_err        out  1   one-cycle strobe with mem_data_wr/wr_done when aborted by timeout
//  rq_dropped     out  1   sticky: a mem_rq_start arrived while busy; cleared only by reset
//  bus_req        out  1   external bus cycle request
//  bus_we         out  1   external bus write enable, valid with bus_req
//  bus_addr       out  16  external byte address
//  bus_dout       out  8   external write byte
//  bus_din        in   8   external read byte, sampled when bus_ack=1
//  bus_ack        in   1   external cycle complete this clock
// BEHAVIOUR
//  Reset (a_rst=0, immediate): state IDLE, MAR=0, all outputs 0, counters 0. Reset mid-
//   transaction aborts it: bus_req drops asynchronously, no wr_done/mem_data_wr is produced.
//  MAR: loaded from mem_rq_addr on prepare_addr in any state. Transaction address/data/cmd/
//   width/tag copied to private txn regs on accept; later MAR writes do not affect active txn.
//  Accept: mem_rq_start=1 in IDLE. If prepare_addr is high the same cycle, mem_rq_addr is used
//   (bypass), else MAR. start while not IDLE: ignored, rq_dropped set.
//  FSM: IDLE -> LO on accept. LO: bus_req=1, bus_addr=txn_addr, bus_we=cmd, bus_dout=data[7:0].
//   LO + bus_ack: capture bus_din into result[7:0]; width=1 -> HI, else DONE.
//   HI: bus_addr=txn_addr+1 (16b wrap: 0xFFFF -> 0x0000), bus_dout=data[15:8];
//   HI + bus_ack: capture result[15:8] -> DONE.  DONE: one cycle, then IDLE.
//  DONE outputs: read -> mem_data_wr=1, mem_data_t_wr=txn_tag, mem_data_in=result; write ->
//   wr_done=1. Byte reads zero-extend ([15:8]=0). mem_data_in holds last value otherwise.
//  Latency (ack in first bus cycle): accept edge N; LO in cycle N+1; DONE strobe in N+2 (byte)
//   or N+3 (word). Each wait cycle (bus_ack=0) adds one.
//  Timeout: per-phase counter reset on entering LO/HI; if TIMEOUT!=0 and counter reaches
//   TIMEOUT with no ack -> DONE with bus_err=1; read result forced to 16'hFFFF; write skips HI.
//  hold = (state != IDLE); a new request is accepted in the cycle after DONE at the earliest.
//  bus_req is never high in IDLE or DONE; bus_we=0 whenever bus_req=0.
// TESTING
//  1 byte read: MAR=0x1234, start cmd=0 w=0 tag=1, bus_din=0xAB ack immediate -> bus_addr=0x1234,
//    2 cycles later mem_data_wr=1, mem_data_in=0x00AB, mem_data_t_wr=1, hold low next cycle.
//  2 word read, 2 wait states per byte: addr 0x2000, din 0x34 then 0x12 -> bus_addr 0x2000 then
//    0x2001, mem_data_in=0x1234 after 7 cycles, mem_data_t_wr=0.
//  3 word write wrap: addr 0xFFFF data 0xBEEF -> bus_we=1, (0xFFFF,0xEF) then (0x0000,0xBE),
//    wr_done one cycle, mem_data_wr never asserted.
//  4 timeout: TIMEOUT=4, word read, ack never -> abort after 4 LO cycles, mem_data_in=0xFFFF,
//    bus_err=1 with mem_data_wr, HI never entered.
//  5 prepare+start same cycle with addr 0x0042 while MAR=0x1111 -> bus_addr=0x0042; second
//    start during LO -> ignored, rq_dropped=1 stays set; prepare during HI does not change bus_addr.
//  6 a_rst low during HI -> bus_req/hold drop immediately, no strobes; after release byte read works.

Source files
------------

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Core memory-request responder. Runs each accepted request as
//                one (byte) or two (word, little-endian) cycles on an 8-bit
//                external bus and returns read data / write completion to the
//                core. One outstanding request; hold is high while busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int TIMEOUT = 16          // bus-phase cycles without ack before abort, 0 = never
) (
    input  logic        clk,
    input  logic        a_rst,
    input  logic        mem_rq_start,
    input  logic        mem_rq_cmd,
    input  logic        mem_rq_width,
    input  logic        mem_rq_prepare_addr,
    input  logic [15:0] mem_rq_addr,
    input  logic [15:0] mem_rq_data,
    input  logic        mem_rq_tag,
    output logic        hold,
    output logic [15:0] mem_data_in,
    output logic        mem_data_wr,
    output logic        mem_data_t_wr,
    output logic        wr_done,
    output logic        bus_err,
    output logic        rq_dropped,
    output logic        bus_req,
    output logic        bus_we,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    input  logic [7:0]  bus_din,
    input  logic        bus_ack
);

    // State encoding
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LO   = 2'd1;
    localparam logic [1:0] c_HI   = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    // Phase counter only needs to reach TIMEOUT-1
    localparam int              c_CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_CW-1:0] c_TMO_LAST = c_CW'(TIMEOUT - 1);
    localparam bit              c_TMO_EN   = (TIMEOUT != 0);

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [15:0]     r_mar;
    logic [15:0]     r_txn_addr;
    logic [15:0]     r_txn_data;
    logic            r_txn_cmd;
    logic            r_txn_width;
    logic            r_txn_tag;
    logic [7:0]      r_result_lo;
    logic [15:0]     r_data_out;
    logic            r_err;
    logic            r_dropped;
    logic [c_CW-1:0] r_cnt;

    logic            w_accept;
    logic            w_in_bus;
    logic            w_tmo;

    assign w_accept = (r_state == c_IDLE) && mem_rq_start;
    assign w_in_bus = (r_state == c_LO) || (r_state == c_HI);
    // Abort fires on the last allowed wait cycle of a phase; an ack that cycle still wins
    assign w_tmo    = c_TMO_EN && w_in_bus && !bus_ack && (r_cnt == c_TMO_LAST);

    // State register
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (mem_rq_start) begin
                    w_next = c_LO;
                end
            end
            c_LO: begin
                if (bus_ack) begin
                    w_next = r_txn_width ? c_HI : c_DONE;
                end else if (w_tmo) begin
                    w_next = c_DONE;
                end
            end
            c_HI: begin
                if (bus_ack || w_tmo) begin
                    w_next = c_DONE;
                end
            end
            default: begin
                w_next = c_IDLE;
            end
        endcase
    end

    // Output decode from current state and active transaction
    always_comb begin
        hold          = (r_state != c_IDLE);
        bus_req       = w_in_bus;
        bus_we        = w_in_bus && r_txn_cmd;
        bus_addr      = 16'h0000;
        bus_dout      = 8'h00;
        mem_data_wr   = 1'b0;
        mem_data_t_wr = 1'b0;
        wr_done       = 1'b0;
        bus_err       = 1'b0;
        case (r_state)
            c_LO: begin
                bus_addr = r_txn_addr;
                bus_dout = r_txn_data[7:0];
            end
            c_HI: begin
                // Natural 16-bit wrap: 0xFFFF + 1 -> 0x0000
                bus_addr = r_txn_addr + 16'd1;
                bus_dout = r_txn_data[15:8];
            end
            c_DONE: begin
                mem_data_wr   = !r_txn_cmd;
                mem_data_t_wr = !r_txn_cmd && r_txn_tag;
                wr_done       = r_txn_cmd;
                bus_err       = r_err;
            end
            default: begin
                bus_addr = 16'h0000;
            end
        endcase
    end

    assign mem_data_in = r_data_out;
    assign rq_dropped  = r_dropped;

    // Address register, loadable in any state
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            r_mar <= 16'h0000;
        end else if (mem_rq_prepare_addr) begin
            r_mar <= mem_rq_addr;
        end
    end

    // Private copy of the request so later MAR writes cannot disturb it
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            r_txn_addr  <= 16'h0000;
            r_txn_data  <= 16'h0000;
            r_txn_cmd   <= 1'b0;
            r_txn_width <= 1'b0;
            r_txn_tag   <= 1'b0;
        end else if (w_accept) begin
            r_txn_addr  <= mem_rq_prepare_addr ? mem_rq_addr : r_mar;
            r_txn_data  <= mem_rq_data;
            r_txn_cmd   <= mem_rq_cmd;
            r_txn_width <= mem_rq_width;
            r_txn_tag   <= mem_rq_tag;
        end
    end

    // Read assembly; the return register only changes when a read completes
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            r_result_lo <= 8'h00;
            r_data_out  <= 16'h0000;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_err <= 1'b0;
            end
            if (r_state == c_LO && bus_ack) begin
                r_result_lo <= bus_din;
                if (!r_txn_cmd && !r_txn_width) begin
                    r_data_out <= {8'h00, bus_din};
                end
            end
            if (r_state == c_HI && bus_ack && !r_txn_cmd) begin
                r_data_out <= {bus_din, r_result_lo};
            end
            if (w_tmo) begin
                r_err <= 1'b1;
                if (!r_txn_cmd) begin
                    r_data_out <= 16'hFFFF;
                end
            end
        end
    end

    // Per-phase wait counter, restarted on every state change
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else if (w_in_bus) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Sticky flag for requests arriving while busy
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            r_dropped <= 1'b0;
        end else if (mem_rq_start && (r_state != c_IDLE)) begin
            r_dropped <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Scoreboard testbench for mem_responder with a byte-wide bus
//                memory model and programmable wait states.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        a_rst;
    logic        mem_rq_start, mem_rq_cmd, mem_rq_width, mem_rq_prepare_addr, mem_rq_tag;
    logic [15:0] mem_rq_addr, mem_rq_data;
    logic        hold, mem_data_wr, mem_data_t_wr, wr_done, bus_err, rq_dropped;
    logic [15:0] mem_data_in;
    logic        bus_req, bus_we, bus_ack;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dout, bus_din;

    mem_responder #(.TIMEOUT(4)) dut (
        .clk                 (clk),
        .a_rst               (a_rst),
        .mem_rq_start        (mem_rq_start),
        .mem_rq_cmd          (mem_rq_cmd),
        .mem_rq_width        (mem_rq_width),
        .mem_rq_prepare_addr (mem_rq_prepare_addr),
        .mem_rq_addr         (mem_rq_addr),
        .mem_rq_data         (mem_rq_data),
        .mem_rq_tag          (mem_rq_tag),
        .hold                (hold),
        .mem_data_in         (mem_data_in),
        .mem_data_wr         (mem_data_wr),
        .mem_data_t_wr       (mem_data_t_wr),
        .wr_done             (wr_done),
        .bus_err             (bus_err),
        .rq_dropped          (rq_dropped),
        .bus_req             (bus_req),
        .bus_we              (bus_we),
        .bus_addr            (bus_addr),
        .bus_dout            (bus_dout),
        .bus_din             (bus_din),
        .bus_ack             (bus_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_wr;
        logic [15:0] data;
        logic        tag;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [23:0] wlog[$];
    logic [7:0]  mem [0:65535];
    int          n_checks = 0;
    int          n_errors = 0;
    int          waits    = 0;
    int          wcnt     = 0;
    bit          ack_en   = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Bus slave: acks after `waits` idle cycles per phase, decided on the falling edge
    always @(negedge clk) begin
        if (!a_rst || !bus_req) begin
            bus_ack = 1'b0;
            wcnt    = 0;
        end else if (ack_en && wcnt == waits) begin
            bus_ack = 1'b1;
            wcnt    = 0;
            if (bus_we) begin
                mem[bus_addr] = bus_dout;
                wlog.push_back({bus_addr, bus_dout});
            end else begin
                bus_din = mem[bus_addr];
            end
        end else begin
            bus_ack = 1'b0;
            wcnt++;
        end
    end

    // Monitor: every completion strobe is matched against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (a_rst) begin
            if (bus_we) chk("we_implies_req", {31'd0, bus_req}, 32'd1);
            if (mem_data_wr || wr_done) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_strobe actual rd=%0d wr=%0d required none",
                             mem_data_wr, wr_done);
                end else begin
                    e = sb.pop_front();
                    chk("resp_kind", {30'd0, mem_data_wr, wr_done}, e.is_wr ? 32'd1 : 32'd2);
                    chk("resp_err", {31'd0, bus_err}, {31'd0, e.err});
                    if (!e.is_wr) begin
                        chk("resp_data", {16'd0, mem_data_in}, {16'd0, e.data});
                        chk("resp_tag", {31'd0, mem_data_t_wr}, {31'd0, e.tag});
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic is_wr, input logic [15:0] data, input logic tag,
                            input logic err);
        exp_t e;
        e.is_wr = is_wr;
        e.data  = data;
        e.tag   = tag;
        e.err   = err;
        sb.push_back(e);
    endtask

    task automatic set_mar(input logic [15:0] a);
        mem_rq_prepare_addr = 1'b1;
        mem_rq_addr         = a;
        tick();
        mem_rq_prepare_addr = 1'b0;
        mem_rq_addr         = 16'h0000;
    endtask

    // Returns at the accept edge + 1 time unit
    task automatic issue(input logic cmd, input logic width, input logic tag,
                         input logic [15:0] data, input logic prep, input logic [15:0] addr);
        mem_rq_start        = 1'b1;
        mem_rq_cmd          = cmd;
        mem_rq_width        = width;
        mem_rq_tag          = tag;
        mem_rq_data         = data;
        mem_rq_prepare_addr = prep;
        mem_rq_addr         = addr;
        tick();
        mem_rq_start        = 1'b0;
        mem_rq_prepare_addr = 1'b0;
        mem_rq_addr         = 16'h0000;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!(mem_data_wr || wr_done) && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int lo_cnt;
        bit hi_seen;

        a_rst = 1'b0;
        mem_rq_start = 1'b0; mem_rq_cmd = 1'b0; mem_rq_width = 1'b0;
        mem_rq_prepare_addr = 1'b0; mem_rq_tag = 1'b0;
        mem_rq_addr = 16'h0000; mem_rq_data = 16'h0000;
        bus_ack = 1'b0; bus_din = 8'h00;
        mem[16'h1234] = 8'hAB;
        mem[16'h2000] = 8'h34; mem[16'h2001] = 8'h12;
        mem[16'h0042] = 8'h11; mem[16'h0043] = 8'h22;
        mem[16'h4000] = 8'hAA; mem[16'h4001] = 8'hBB;
        mem[16'h0077] = 8'h5A;

        // Reset state
        repeat (3) tick();
        chk("rst_hold", {31'd0, hold}, 32'd0);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_data_in", {16'd0, mem_data_in}, 32'd0);
        chk("rst_dropped", {31'd0, rq_dropped}, 32'd0);
        chk("rst_strobes", {30'd0, mem_data_wr, wr_done}, 32'd0);
        a_rst = 1'b1;
        tick();

        // 1: byte read from MAR, immediate ack
        waits = 0;
        set_mar(16'h1234);
        push_exp(1'b0, 16'h00AB, 1'b1, 1'b0);
        issue(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000);
        chk("t1_addr", {16'd0, bus_addr}, 32'h1234);
        chk("t1_req", {31'd0, bus_req}, 32'd1);
        chk("t1_we", {31'd0, bus_we}, 32'd0);
        chk("t1_hold", {31'd0, hold}, 32'd1);
        wait_done(n);
        chk("t1_latency", n, 32'd1);
        tick();
        chk("t1_hold_after", {31'd0, hold}, 32'd0);

        // 2: word read, two wait states per byte
        waits = 2;
        push_exp(1'b0, 16'h1234, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h2000);
        chk("t2_addr_lo", {16'd0, bus_addr}, 32'h2000);
        repeat (3) tick();
        chk("t2_addr_hi", {16'd0, bus_addr}, 32'h2001);
        wait_done(n);
        chk("t2_latency", n, 32'd3);
        tick();

        // 3: word write wrapping past 0xFFFF
        waits = 0;
        wlog.delete();
        push_exp(1'b1, 16'h0000, 1'b0, 1'b0);
        issue(1'b1, 1'b1, 1'b0, 16'hBEEF, 1'b1, 16'hFFFF);
        chk("t3_we", {31'd0, bus_we}, 32'd1);
        chk("t3_lo", {8'd0, bus_addr, bus_dout}, 32'h00FFFFEF);
        tick();
        chk("t3_hi", {8'd0, bus_addr, bus_dout}, 32'h000000BE);
        wait_done(n);
        chk("t3_latency", n, 32'd1);
        chk("t3_wlog_n", wlog.size(), 32'd2);
        if (wlog.size() == 2) begin
            chk("t3_wlog0", {8'd0, wlog[0]}, 32'h00FFFFEF);
            chk("t3_wlog1", {8'd0, wlog[1]}, 32'h000000BE);
        end
        tick();

        // 4: timeout on the low byte of a word read
        ack_en = 1'b0;
        push_exp(1'b0, 16'hFFFF, 1'b1, 1'b1);
        issue(1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h3000);
        lo_cnt  = 0;
        hi_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (mem_data_wr || wr_done) break;
            if (bus_req) lo_cnt++;
            if (bus_req && bus_addr == 16'h3001) hi_seen = 1'b1;
            tick();
        end
        chk("t4_lo_cycles", lo_cnt, 32'd4);
        chk("t4_hi_seen", {31'd0, hi_seen}, 32'd0);
        tick();
        ack_en = 1'b1;

        // 5: bypass address, dropped start, MAR write during HI
        waits = 2;
        set_mar(16'h1111);
        push_exp(1'b0, 16'h2211, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0042);
        chk("t5_bypass_addr", {16'd0, bus_addr}, 32'h0042);
        mem_rq_start = 1'b1;
        tick();
        mem_rq_start = 1'b0;
        chk("t5_dropped", {31'd0, rq_dropped}, 32'd1);
        repeat (2) tick();
        chk("t5_addr_hi", {16'd0, bus_addr}, 32'h0043);
        mem_rq_prepare_addr = 1'b1;
        mem_rq_addr         = 16'h5555;
        tick();
        mem_rq_prepare_addr = 1'b0;
        mem_rq_addr         = 16'h0000;
        chk("t5_addr_hi_kept", {16'd0, bus_addr}, 32'h0043);
        wait_done(n);
        chk("t5_latency", n, 32'd2);
        tick();
        chk("t5_dropped_sticky", {31'd0, rq_dropped}, 32'd1);

        // 6: reset during HI aborts silently
        waits = 2;
        issue(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h4000);
        repeat (3) tick();
        chk("t6_addr_hi", {16'd0, bus_addr}, 32'h4001);
        a_rst = 1'b0;
        #1;
        chk("t6_req_async", {31'd0, bus_req}, 32'd0);
        chk("t6_hold_async", {31'd0, hold}, 32'd0);
        repeat (2) tick();
        a_rst = 1'b1;
        tick();
        chk("t6_dropped_cleared", {31'd0, rq_dropped}, 32'd0);
        chk("t6_hold_idle", {31'd0, hold}, 32'd0);
        waits = 1;
        push_exp(1'b0, 16'h005A, 1'b0, 1'b0);
        issue(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0077);
        wait_done(n);
        chk("t6_latency", n, 32'd2);

        repeat (3) tick();
        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
